// File: rtl/decode38_filt.sv
// decode38_filt: registered 3-to-8 decoder behind a stability filter.
// A {valid, code} sample must hold for STABLE_CYCLES consecutive edges before
// it is committed to the one-hot, code, seven-segment and valid outputs.
// Bouncing switch or encoder inputs are therefore tolerated; only a value that
// actually settles reaches the pins, and o_change marks a genuinely new value.
module decode38_filt #(
  parameter int STABLE_CYCLES = 4  // legal range 2..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_code,
  input  logic       i_valid,
  output logic [7:0] o_onehot,
  output logic [2:0] o_code,
  output logic [7:0] o_seg,
  output logic       o_valid,
  output logic       o_change
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

  // SETTLE while a candidate is still being qualified, HOLD once it has been
  // committed; the state is implied by the counter value, not stored apart.
  typedef enum logic {SETTLE, HOLD} state_t;

  logic [3:0]    sample;       // {valid, masked code}
  logic [3:0]    cand_reg;
  logic [3:0]    cand_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [3:0]    comm_reg;
  logic          commit;
  state_t        state;
  logic [7:0]    dec_onehot;
  logic [7:0]    dec_seg;

  // Code is forced to 0 while invalid so code wiggles under valid=0 are unseen.
  assign sample = {i_valid, (i_valid ? i_code : 3'd0)};

  assign state = (cnt_reg == CNT_FULL) ? HOLD : SETTLE;

  // Next candidate/count and commit decision; any differing sample restarts.
  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    commit    = 1'b0;
    if (sample != cand_reg) begin
      cand_next = sample;
      cnt_next  = CNT_ONE;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = CNT_FULL;
      commit   = 1'b1;
    end else if (state == SETTLE) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // One-hot decode of the candidate; all-zero when the candidate is invalid.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign dec_onehot[gi] = cand_reg[3] && (cand_reg[2:0] == 3'(gi));
    end
  endgenerate

  // Active-low seven-segment pattern {dp,g,f,e,d,c,b,a}; blank when invalid.
  always_comb begin
    dec_seg = 8'hFF;
    if (cand_reg[3]) begin
      case (cand_reg[2:0])
        3'd0:    dec_seg = 8'hC0;
        3'd1:    dec_seg = 8'hF9;
        3'd2:    dec_seg = 8'hA4;
        3'd3:    dec_seg = 8'hB0;
        3'd4:    dec_seg = 8'h99;
        3'd5:    dec_seg = 8'h92;
        3'd6:    dec_seg = 8'h82;
        default: dec_seg = 8'hF8;
      endcase
    end
  end

  // Filter state plus registered outputs; outputs move only on a commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg <= 4'h0;
      cnt_reg  <= CNT_FULL;
      comm_reg <= 4'h0;
      o_onehot <= 8'h00;
      o_code   <= 3'd0;
      o_seg    <= 8'hFF;
      o_valid  <= 1'b0;
      o_change <= 1'b0;
    end else begin
      cand_reg <= cand_next;
      cnt_reg  <= cnt_next;
      o_change <= 1'b0;
      if (commit) begin
        // Re-committing the same value after a bounce leaves o_change low.
        comm_reg <= cand_reg;
        o_onehot <= dec_onehot;
        o_code   <= cand_reg[2:0];
        o_seg    <= dec_seg;
        o_valid  <= cand_reg[3];
        o_change <= (cand_reg != comm_reg);
      end
    end
  end

endmodule

// File: tb/tb_decode38_filt.sv
// Bench for decode38_filt: a table of per-edge vectors for the 4-cycle filter,
// then a hand-written never-stable sequence checked on both a 4-cycle and a
// 2-cycle instance driven by the same inputs.
module tb_decode38_filt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code = 3'd0;
  logic       vld = 1'b0;

  logic [7:0] oh4, seg4, oh2, seg2;
  logic [2:0] oc4, oc2;
  logic       ov4, ch4, ov2, ch2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode38_filt #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .i_code(code), .i_valid(vld),
    .o_onehot(oh4), .o_code(oc4), .o_seg(seg4), .o_valid(ov4), .o_change(ch4)
  );

  decode38_filt #(.STABLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .i_code(code), .i_valid(vld),
    .o_onehot(oh2), .o_code(oc2), .o_seg(seg2), .o_valid(ov2), .o_change(ch2)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] c;
    logic [7:0] oh;
    logic [2:0] oc;
    logic [7:0] seg;
    logic       ov;
    logic       ch;
  } vec_t;

  vec_t vq[$];

  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  task automatic add(input logic r, input logic v, input logic [2:0] c,
                     input logic [7:0] oh, input logic [2:0] oc, input logic [7:0] sg,
                     input logic ov, input logic ch);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.oh = oh; t.oc = oc; t.seg = sg; t.ov = ov; t.ch = ch;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp2;
    logic       exp2_ch;
    logic [2:0] cur;

    // Reset with arbitrary inputs
    add(1, 1, 3'd6, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(1, 0, 3'd3, 8'h00, 3'd0, 8'hFF, 0, 0);
    // Commit code 5 on the 4th edge it is sampled
    add(0, 1, 3'd5, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd5, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd5, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 1);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    // Two-cycle glitch to 3, back to 5: identical re-commit, no pulse
    add(0, 1, 3'd3, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd3, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd5, 8'h20, 3'd5, 8'h92, 1, 0);
    // Commit code 7
    add(0, 1, 3'd7, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd7, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd7, 8'h20, 3'd5, 8'h92, 1, 0);
    add(0, 1, 3'd7, 8'h80, 3'd7, 8'hF8, 1, 1);
    add(0, 1, 3'd7, 8'h80, 3'd7, 8'hF8, 1, 0);
    // Invalid with toggling code: commits blank after 4 edges
    add(0, 0, 3'd1, 8'h80, 3'd7, 8'hF8, 1, 0);
    add(0, 0, 3'd6, 8'h80, 3'd7, 8'hF8, 1, 0);
    add(0, 0, 3'd2, 8'h80, 3'd7, 8'hF8, 1, 0);
    add(0, 0, 3'd5, 8'h00, 3'd0, 8'hFF, 0, 1);
    add(0, 0, 3'd4, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 0, 3'd3, 8'h00, 3'd0, 8'hFF, 0, 0);
    // Code 2, reset after 2 samples, then a full 4 samples after release
    add(0, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(1, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd2, 8'h00, 3'd0, 8'hFF, 0, 0);
    add(0, 1, 3'd2, 8'h04, 3'd2, 8'hA4, 1, 1);

    foreach (vq[i]) begin
      rst  = vq[i].r;
      vld  = vq[i].v;
      code = vq[i].c;
      step();
      $display("[TB] vec %0d rst=%0d v=%0d c=%0d -> oh=%h code=%0d seg=%h v=%0d ch=%0d",
               i, rst, vld, code, oh4, oc4, seg4, ov4, ch4);
      check($sformatf("vec%0d onehot", i), oh4, vq[i].oh);
      check($sformatf("vec%0d code", i), {5'd0, oc4}, {5'd0, vq[i].oc});
      check($sformatf("vec%0d seg", i), seg4, vq[i].seg);
      check($sformatf("vec%0d valid", i), {7'd0, ov4}, {7'd0, vq[i].ov});
      check($sformatf("vec%0d change", i), {7'd0, ch4}, {7'd0, vq[i].ch});
    end

    // Never-stable input: 1 and 6 alternate every 3 cycles. The 4-cycle
    // filter keeps code 2; the 2-cycle one commits each value on its 2nd edge.
    rst = 1'b0;
    vld = 1'b1;
    exp2 = 3'd2;
    for (int i = 0; i < 50; i++) begin
      cur  = (((i / 3) % 2) == 1) ? 3'd6 : 3'd1;
      code = cur;
      exp2_ch = 1'b0;
      if ((i % 3) == 1) begin
        exp2    = cur;
        exp2_ch = 1'b1;
      end
      step();
      $display("[TB] bounce %0d c=%0d -> s4 oh=%h ch=%0d | s2 oh=%h code=%0d ch=%0d",
               i, cur, oh4, ch4, oh2, oc2, ch2);
      check($sformatf("ns%0d s4 onehot", i), oh4, 8'h04);
      check($sformatf("ns%0d s4 code", i), {5'd0, oc4}, 8'd2);
      check($sformatf("ns%0d s4 seg", i), seg4, 8'hA4);
      check($sformatf("ns%0d s4 valid", i), {7'd0, ov4}, 8'd1);
      check($sformatf("ns%0d s4 change", i), {7'd0, ch4}, 8'd0);
      check($sformatf("ns%0d s2 onehot", i), oh2, 8'h01 << exp2);
      check($sformatf("ns%0d s2 code", i), {5'd0, oc2}, {5'd0, exp2});
      check($sformatf("ns%0d s2 seg", i), seg2, seg_tab[exp2]);
      check($sformatf("ns%0d s2 valid", i), {7'd0, ov2}, 8'd1);
      check($sformatf("ns%0d s2 change", i), {7'd0, ch2}, {7'd0, exp2_ch});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
